// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: drives the D/En write port of a level-sensitive latch bank
// from a valid/ready source, with programmable setup, pulse and hold windows.
// Optional build macro: READBACK_CHECK_EN adds the Q readback input and the sticky Err flag.
module latch_write_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] In_data,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] D,
    output logic             En,
    output logic             Busy,
`ifdef READBACK_CHECK_EN
    input  logic [WIDTH-1:0] Q,
    output logic             Err,
`endif
    output logic             Done
);

    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);

    // Every window needs at least one cycle or the latch timing is meaningless.
    if (SETUP_CYC < 1) begin : gSetupChk
        $error("latch_write_sequencer: SETUP_CYC must be >= 1");
    end
    if (PULSE_CYC < 1) begin : gPulseChk
        $error("latch_write_sequencer: PULSE_CYC must be >= 1");
    end
    if (HOLD_CYC < 1) begin : gHoldChk
        $error("latch_write_sequencer: HOLD_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } stateT;

    stateT           stateQ, stateNxt;
    logic [CW-1:0]   cntQ, cntNxt;
    logic            enNxt;
    logic            accept;
    logic            cntZero;

    assign In_ready = (stateQ == IDLE);
    assign Busy     = ~In_ready;
    assign accept   = In_valid & In_ready;
    assign cntZero  = (cntQ == '0);
    // Last HOLD cycle: D has been stable for the full hold window by the closing edge.
    assign Done     = (stateQ == HOLD) & cntZero;

    // State, window counter, data and enable registers; En comes straight from a flop.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            D      <= '0;
            En     <= 1'b0;
        end else begin
            stateQ <= stateNxt;
            cntQ   <= cntNxt;
            En     <= enNxt;
            if (accept) D <= In_data;
        end
    end

    // Next-state logic: each window counts down from N-1 and advances on zero.
    always_comb begin
        stateNxt = stateQ;
        cntNxt   = cntQ;
        enNxt    = En;
        case (stateQ)
            IDLE: begin
                if (In_valid) begin
                    stateNxt = SETUP;
                    cntNxt   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cntZero) begin
                    stateNxt = PULSE;
                    cntNxt   = PULSE_LOAD;
                    enNxt    = 1'b1;
                end else begin
                    cntNxt = cntQ - 1'b1;
                end
            end
            PULSE: begin
                if (cntZero) begin
                    stateNxt = HOLD;
                    cntNxt   = HOLD_LOAD;
                    enNxt    = 1'b0;
                end else begin
                    cntNxt = cntQ - 1'b1;
                end
            end
            HOLD: begin
                if (cntZero) begin
                    stateNxt = IDLE;
                end else begin
                    cntNxt = cntQ - 1'b1;
                end
            end
            default: begin
                stateNxt = IDLE;
                enNxt    = 1'b0;
            end
        endcase
    end

`ifdef READBACK_CHECK_EN
    // Sticky readback error: set when the latch outputs disagree with D at the end of hold.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Err <= 1'b0;
        end else if (accept) begin
            Err <= 1'b0;
        end else if (Done && (Q != D)) begin
            Err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer: default-parameter instance plus an
// S=3/P=1/H=2 instance; written words go through a scoreboard checked at Done.
module tb_latch_write_sequencer;

    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;
    localparam int L = S + P + H;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [7:0] inData, d;
    logic       inValid, inReady, en, busy, done;
    logic [7:0] inDataB, dB;
    logic       inValidB, inReadyB, enB, busyB, doneB;
`ifdef READBACK_CHECK_EN
    logic [7:0] q, qB;
    logic [7:0] stuckMask = 8'hFF;
    logic       err, errB;
`endif

    int         cyc = 0;
    int         passCnt = 0;
    int         totalCnt = 0;
    logic [7:0] sbQ[$];
    logic [7:0] curD;
    int         firstAcc, secondAcc;

    latch_write_sequencer #(.WIDTH(8), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dutA (
        .Clk(Clk), .Rst_n(Rst_n), .In_data(inData), .In_valid(inValid), .In_ready(inReady),
        .D(d), .En(en), .Busy(busy),
`ifdef READBACK_CHECK_EN
        .Q(q), .Err(err),
`endif
        .Done(done));

    latch_write_sequencer #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dutB (
        .Clk(Clk), .Rst_n(Rst_n), .In_data(inDataB), .In_valid(inValidB), .In_ready(inReadyB),
        .D(dB), .En(enB), .Busy(busyB),
`ifdef READBACK_CHECK_EN
        .Q(qB), .Err(errB),
`endif
        .Done(doneB));

`ifdef READBACK_CHECK_EN
    // Latch bank models; dutA's can have stuck-at-0 bits via stuckMask.
    always_latch if (en) q = d & stuckMask;
    always_latch if (enB) qB = dB;
`endif

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Present a word, wait (bounded) for In_ready, let it be accepted, push expected D.
    task automatic acceptWord(input logic [7:0] data);
        int n = 0;
        inData  = data;
        inValid = 1'b1;
        while (!inReady && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("ready_wait", inReady, 1);
        @(posedge Clk); #1;
        inValid = 1'b0;
        sbQ.push_back(data);
        curD     = data;
        secondAcc = firstAcc;
        firstAcc  = cyc;
    endtask

    // Walk the L busy cycles after an accept edge and check the write waveform.
    task automatic runSeq(input bit toggle, input bit holdValid, input logic [7:0] nextData);
        logic [7:0] exp;
        for (int k = 0; k < L; k++) begin
            if (toggle) begin
                inData  = k[0] ? 8'hFF : 8'h00;
                inValid = 1'b1;
            end else if (holdValid) begin
                inData  = nextData;
                inValid = 1'b1;
            end
            chk($sformatf("en_k%0d", k), en, (k >= S && k < S + P));
            chk($sformatf("done_k%0d", k), done, (k == L - 1));
            chk($sformatf("ready_k%0d", k), inReady, 0);
            chk($sformatf("d_k%0d", k), d, curD);
            if (done) begin
                exp = (sbQ.size() > 0) ? sbQ.pop_front() : 8'hXX;
                chk("sb_d", d, exp);
            end
            @(posedge Clk); #1;
        end
        if (toggle) inValid = 1'b0;
        chk("ready_end", inReady, 1);
        chk("en_end", en, 0);
        chk("done_end", done, 0);
    endtask

    initial begin
        int busyCnt;
        logic [7:0] exp;
        Rst_n = 1'b0; inData = '0; inValid = 1'b0; inDataB = '0; inValidB = 1'b0;
        firstAcc = 0; secondAcc = 0; curD = '0;
        #2;
        // Reset state
        chk("rst_d", d, 8'h00);
        chk("rst_en", en, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", inReady, 1);
        chk("rst_busy", busy, 0);
        #10 Rst_n = 1'b1;
        @(posedge Clk); #1;

        // Single write with default windows
        acceptWord(8'hA5);
        runSeq(1'b0, 1'b0, 8'h00);
`ifdef READBACK_CHECK_EN
        chk("err_clean", err, 0);
`endif

        // Back-to-back: valid held high, next word waits for the return to IDLE
        acceptWord(8'hA5);
        runSeq(1'b0, 1'b1, 8'h3C);
        acceptWord(8'h3C);
        chk("b2b_spacing", firstAcc - secondAcc, L + 1);
        runSeq(1'b0, 1'b0, 8'h00);

        // In_data toggling while busy is ignored
        acceptWord(8'h5A);
        runSeq(1'b1, 1'b0, 8'h00);
        chk("toggle_d_after", d, 8'h5A);

        // Asynchronous reset in the middle of PULSE
        acceptWord(8'hC3);
        @(posedge Clk); #1;
        chk("mid_pulse_en", en, 1);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_en", en, 0);
        chk("arst_d", d, 8'h00);
        chk("arst_done", done, 0);
        sbQ.delete();
        #10 Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("arst_ready", inReady, 1);
        chk("arst_en_after", en, 0);

        // Non-default windows on dutB: S=3 P=1 H=2
        inDataB = 8'h81; inValidB = 1'b1;
        @(posedge Clk); #1;
        inValidB = 1'b0;
        sbQ.push_back(8'h81);
        busyCnt = 0;
        for (int k = 0; k < 6; k++) begin
            inDataB = 8'h00;
            busyCnt += busyB;
            chk($sformatf("b_en_k%0d", k), enB, (k == 3));
            chk($sformatf("b_done_k%0d", k), doneB, (k == 5));
            chk($sformatf("b_d_k%0d", k), dB, 8'h81);
            if (doneB) begin
                exp = (sbQ.size() > 0) ? sbQ.pop_front() : 8'hXX;
                chk("b_sb_d", dB, exp);
            end
            @(posedge Clk); #1;
        end
        chk("b_busy_cycles", busyCnt, 6);
        chk("b_ready_end", inReadyB, 1);

`ifdef READBACK_CHECK_EN
        // Readback: bit 0 stuck at 0 flags Err; next accept clears it
        stuckMask = 8'hFE;
        acceptWord(8'h01);
        runSeq(1'b0, 1'b0, 8'h00);
        chk("err_set", err, 1);
        acceptWord(8'h02);
        chk("err_clr_accept", err, 0);
        runSeq(1'b0, 1'b0, 8'h00);
        chk("err_stays_clr", err, 0);
`endif

        chk("sb_empty", sbQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
